// File: rtl/prio_demux_pkg.sv
// Shared types and the destination priority rule for the registered
// 1-to-3 priority demultiplexer (return path of the three-source selector).
package prio_demux_pkg;

  typedef enum logic [1:0] {
    DST_X = 2'd0,
    DST_Y = 2'd1,
    DST_Z = 2'd2
  } dst_t;

  // c2 beats c1, and c1 beats the default destination X. The selector's
  // bench model calls this same function, so both directions agree.
  function automatic dst_t dst_sel(input logic c1, input logic c2);
    dst_t d;
    if (c2) begin
      d = DST_Z;
    end else if (c1) begin
      d = DST_Y;
    end else begin
      d = DST_X;
    end
    return d;
  endfunction

endpackage

// File: rtl/demux_slot.sv
// One destination slot: a one-entry valid/data register feeding a sink,
// plus a counter of words that sink has taken.
module demux_slot #(
  parameter int WIDTH   = 8,
  parameter int COUNT_W = 16
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               load,
  input  logic [WIDTH-1:0]   load_data,
  input  logic               ready,
  output logic               valid,
  output logic [WIDTH-1:0]   data,
  input  logic               clr_cnt,
  output logic [COUNT_W-1:0] cnt
);

  // A load always wins, which is what lets a drain and a refill share a
  // cycle without a bubble. Data keeps its last value after a plain drain.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      valid <= 1'b0;
      data  <= '0;
    end else if (load) begin
      valid <= 1'b1;
      data  <= load_data;
    end else if (valid && ready) begin
      valid <= 1'b0;
    end
  end

  // Count one per completed drain. A clear in the same cycle takes
  // priority, so that beat is deliberately not counted.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      cnt <= '0;
    end else if (clr_cnt) begin
      cnt <= '0;
    end else if (valid && ready) begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/prio_demux_reg.sv
// Registered 1-to-3 priority demultiplexer with valid/ready flow control.
// The top only picks the destination, gates in_ready on that slot being
// free and decodes which slot loads; all storage lives in demux_slot.
module prio_demux_reg
  import prio_demux_pkg::*;
#(
  parameter int WIDTH   = 8,
  parameter int COUNT_W = 16
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   in_data,
  input  logic               c1,
  input  logic               c2,
  input  logic               clr_cnt,
  output logic               out0_valid,
  output logic               out1_valid,
  output logic               out2_valid,
  input  logic               out0_ready,
  input  logic               out1_ready,
  input  logic               out2_ready,
  output logic [WIDTH-1:0]   out0_data,
  output logic [WIDTH-1:0]   out1_data,
  output logic [WIDTH-1:0]   out2_data,
  output logic [COUNT_W-1:0] cnt0,
  output logic [COUNT_W-1:0] cnt1,
  output logic [COUNT_W-1:0] cnt2
);

  dst_t dst;
  logic free0;
  logic free1;
  logic free2;
  logic load0;
  logic load1;
  logic load2;

  assign dst = dst_sel(c1, c2);

  // A slot can take a word when empty, or when its current word leaves
  // this same cycle. in_valid is kept out of this path on purpose.
  assign free0 = !out0_valid || out0_ready;
  assign free1 = !out1_valid || out1_ready;
  assign free2 = !out2_valid || out2_ready;

  // Steer in_ready from the selected slot and raise that slot's load only
  // on an actual handshake; the other two slots never see the word.
  always_comb begin
    in_ready = 1'b0;
    load0    = 1'b0;
    load1    = 1'b0;
    load2    = 1'b0;
    case (dst)
      DST_X:   in_ready = free0;
      DST_Y:   in_ready = free1;
      DST_Z:   in_ready = free2;
      default: in_ready = 1'b0;
    endcase
    load0 = in_valid && in_ready && (dst == DST_X);
    load1 = in_valid && in_ready && (dst == DST_Y);
    load2 = in_valid && in_ready && (dst == DST_Z);
  end

  demux_slot #(.WIDTH(WIDTH), .COUNT_W(COUNT_W)) u_slot0 (
    .clock     (clock),
    .reset     (reset),
    .load      (load0),
    .load_data (in_data),
    .ready     (out0_ready),
    .valid     (out0_valid),
    .data      (out0_data),
    .clr_cnt   (clr_cnt),
    .cnt       (cnt0)
  );

  demux_slot #(.WIDTH(WIDTH), .COUNT_W(COUNT_W)) u_slot1 (
    .clock     (clock),
    .reset     (reset),
    .load      (load1),
    .load_data (in_data),
    .ready     (out1_ready),
    .valid     (out1_valid),
    .data      (out1_data),
    .clr_cnt   (clr_cnt),
    .cnt       (cnt1)
  );

  demux_slot #(.WIDTH(WIDTH), .COUNT_W(COUNT_W)) u_slot2 (
    .clock     (clock),
    .reset     (reset),
    .load      (load2),
    .load_data (in_data),
    .ready     (out2_ready),
    .valid     (out2_valid),
    .data      (out2_data),
    .clr_cnt   (clr_cnt),
    .cnt       (cnt2)
  );

endmodule

// File: tb/tb_prio_demux_reg.sv
// Directed bench for prio_demux_reg with a 4-bit counter so the wrap case
// is reachable in a handful of cycles.
module tb_prio_demux_reg;

  localparam int WIDTH   = 8;
  localparam int COUNT_W = 4;

  logic               clock;
  logic               reset;
  logic               in_valid;
  logic               in_ready;
  logic [WIDTH-1:0]   in_data;
  logic               c1;
  logic               c2;
  logic               clr_cnt;
  logic               out0_valid;
  logic               out1_valid;
  logic               out2_valid;
  logic               out0_ready;
  logic               out1_ready;
  logic               out2_ready;
  logic [WIDTH-1:0]   out0_data;
  logic [WIDTH-1:0]   out1_data;
  logic [WIDTH-1:0]   out2_data;
  logic [COUNT_W-1:0] cnt0;
  logic [COUNT_W-1:0] cnt1;
  logic [COUNT_W-1:0] cnt2;

  int checkCount;
  int passCount;

  prio_demux_reg #(.WIDTH(WIDTH), .COUNT_W(COUNT_W)) dut (
    .clock      (clock),
    .reset      (reset),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_data    (in_data),
    .c1         (c1),
    .c2         (c2),
    .clr_cnt    (clr_cnt),
    .out0_valid (out0_valid),
    .out1_valid (out1_valid),
    .out2_valid (out2_valid),
    .out0_ready (out0_ready),
    .out1_ready (out1_ready),
    .out2_ready (out2_ready),
    .out0_data  (out0_data),
    .out1_data  (out1_data),
    .out2_data  (out2_data),
    .cnt0       (cnt0),
    .cnt1       (cnt1),
    .cnt2       (cnt2)
  );

  // 10 time-unit clock
  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    checkCount++;
    if (actual === expected) begin
      passCount++;
    end else begin
      $display("[TB] FAIL %s: got %0h, expected %0h", tag, actual, expected);
    end
  endtask

  // Set the input-side signals, then let combinational logic settle.
  task automatic applyStimulus(input logic v, input logic s1, input logic s2, input logic [WIDTH-1:0] d);
    in_valid = v;
    c1       = s1;
    c2       = s2;
    in_data  = d;
    #1;
  endtask

  // Advance one clock edge and sample 1 unit later.
  task automatic waitCycle();
    @(posedge clock);
    #1;
  endtask

  initial begin
    checkCount = 0;
    passCount  = 0;
    reset      = 1'b1;
    in_valid   = 1'b0;
    in_data    = '0;
    c1         = 1'b0;
    c2         = 1'b0;
    clr_cnt    = 1'b0;
    out0_ready = 1'b0;
    out1_ready = 1'b0;
    out2_ready = 1'b0;

    // Reset state
    waitCycle();
    waitCycle();
    checkOutput("rst_v0", 32'(out0_valid), 32'd0);
    checkOutput("rst_v1", 32'(out1_valid), 32'd0);
    checkOutput("rst_v2", 32'(out2_valid), 32'd0);
    checkOutput("rst_d0", 32'(out0_data), 32'd0);
    checkOutput("rst_cnt0", 32'(cnt0), 32'd0);
    reset = 1'b0;
    #1;
    checkOutput("rst_in_ready", 32'(in_ready), 32'd1);

    // Default destination X
    applyStimulus(1'b1, 1'b0, 1'b0, 8'hA5);
    checkOutput("t1_in_ready", 32'(in_ready), 32'd1);
    waitCycle();
    applyStimulus(1'b0, 1'b0, 1'b0, 8'h00);
    checkOutput("t1_v0", 32'(out0_valid), 32'd1);
    checkOutput("t1_d0", 32'(out0_data), 32'hA5);
    checkOutput("t1_v1", 32'(out1_valid), 32'd0);
    checkOutput("t1_v2", 32'(out2_valid), 32'd0);

    // c2 beats c1
    applyStimulus(1'b1, 1'b1, 1'b1, 8'h3C);
    waitCycle();
    applyStimulus(1'b0, 1'b0, 1'b0, 8'h00);
    checkOutput("t2_v2", 32'(out2_valid), 32'd1);
    checkOutput("t2_d2", 32'(out2_data), 32'h3C);
    checkOutput("t2_v1", 32'(out1_valid), 32'd0);
    checkOutput("t2_d0", 32'(out0_data), 32'hA5);
    checkOutput("t2_v0", 32'(out0_valid), 32'd1);

    // Drain 3C from slot 2 while clearing counters: the beat is not counted
    out2_ready = 1'b1;
    clr_cnt    = 1'b1;
    waitCycle();
    clr_cnt = 1'b0;
    checkOutput("clr2_v2", 32'(out2_valid), 32'd0);
    checkOutput("clr2_cnt2", 32'(cnt2), 32'd0);

    // Stream 4 words to slot 2 while slot 0 is stalled
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1'b1, 1'b0, 1'b1, 8'(8'h10 + i));
      checkOutput("t4_in_ready", 32'(in_ready), 32'd1);
      waitCycle();
      checkOutput("t4_v2", 32'(out2_valid), 32'd1);
      checkOutput("t4_d2", 32'(out2_data), 32'(8'h10 + i));
      checkOutput("t4_cnt2", 32'(cnt2), 32'(i));
    end
    applyStimulus(1'b0, 1'b0, 1'b0, 8'h00);
    waitCycle();
    out2_ready = 1'b0;
    checkOutput("t4_cnt2_final", 32'(cnt2), 32'd4);
    checkOutput("t4_v2_final", 32'(out2_valid), 32'd0);
    checkOutput("t4_d0", 32'(out0_data), 32'hA5);
    checkOutput("t4_v0", 32'(out0_valid), 32'd1);
    checkOutput("t4_cnt0", 32'(cnt0), 32'd0);

    // Slot 1 backpressure, then drain-and-refill in one cycle
    applyStimulus(1'b1, 1'b1, 1'b0, 8'h5A);
    waitCycle();
    applyStimulus(1'b1, 1'b1, 1'b0, 8'h6B);
    checkOutput("t3_in_ready_stall", 32'(in_ready), 32'd0);
    waitCycle();
    checkOutput("t3_d1_held", 32'(out1_data), 32'h5A);
    checkOutput("t3_v1_held", 32'(out1_valid), 32'd1);
    out1_ready = 1'b1;
    #1;
    checkOutput("t3_in_ready_free", 32'(in_ready), 32'd1);
    waitCycle();
    applyStimulus(1'b0, 1'b0, 1'b0, 8'h00);
    out1_ready = 1'b0;
    #1;
    checkOutput("t3_v1", 32'(out1_valid), 32'd1);
    checkOutput("t3_d1", 32'(out1_data), 32'h6B);
    checkOutput("t3_cnt1", 32'(cnt1), 32'd1);

    // cnt0 wrap: A5 plus 15 streamed words gives 16 drains
    out0_ready = 1'b1;
    for (int i = 0; i < 15; i++) begin
      applyStimulus(1'b1, 1'b0, 1'b0, 8'(8'h80 + i));
      waitCycle();
    end
    checkOutput("wrap_cnt0_15", 32'(cnt0), 32'd15);
    checkOutput("wrap_d0_last", 32'(out0_data), 32'h8E);
    applyStimulus(1'b0, 1'b0, 1'b0, 8'h00);
    waitCycle();
    out0_ready = 1'b0;
    checkOutput("wrap_cnt0_0", 32'(cnt0), 32'd0);
    checkOutput("wrap_v0", 32'(out0_valid), 32'd0);
    checkOutput("wrap_d0_kept", 32'(out0_data), 32'h8E);

    // clr_cnt together with a slot 1 drain
    out1_ready = 1'b1;
    clr_cnt    = 1'b1;
    waitCycle();
    out1_ready = 1'b0;
    clr_cnt    = 1'b0;
    checkOutput("clr_cnt1", 32'(cnt1), 32'd0);
    checkOutput("clr_cnt2", 32'(cnt2), 32'd0);
    checkOutput("clr_v1", 32'(out1_valid), 32'd0);

    // Fill all slots, with one counted drain on slot 0
    applyStimulus(1'b1, 1'b0, 1'b0, 8'h01);
    waitCycle();
    out0_ready = 1'b1;
    applyStimulus(1'b1, 1'b0, 1'b0, 8'h02);
    waitCycle();
    out0_ready = 1'b0;
    applyStimulus(1'b1, 1'b1, 1'b0, 8'h03);
    waitCycle();
    applyStimulus(1'b1, 1'b0, 1'b1, 8'h04);
    waitCycle();
    applyStimulus(1'b0, 1'b0, 1'b0, 8'h00);
    checkOutput("pre_v0", 32'(out0_valid), 32'd1);
    checkOutput("pre_d0", 32'(out0_data), 32'h02);
    checkOutput("pre_v1", 32'(out1_valid), 32'd1);
    checkOutput("pre_v2", 32'(out2_valid), 32'd1);
    checkOutput("pre_cnt0", 32'(cnt0), 32'd1);

    // Asynchronous reset mid-cycle
    @(posedge clock);
    #3;
    reset = 1'b1;
    #1;
    checkOutput("arst_v0", 32'(out0_valid), 32'd0);
    checkOutput("arst_v1", 32'(out1_valid), 32'd0);
    checkOutput("arst_v2", 32'(out2_valid), 32'd0);
    checkOutput("arst_d1", 32'(out1_data), 32'd0);
    checkOutput("arst_cnt0", 32'(cnt0), 32'd0);
    checkOutput("arst_in_ready", 32'(in_ready), 32'd1);
    waitCycle();
    reset = 1'b0;
    waitCycle();

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
